// File: rtl/nn_pkg.sv
// Shared definitions for the network readout blocks.
package nn_pkg;

    localparam int N_CLASSES_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } argmax_state_t;

    // Index width able to address n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_argmax_reader.sv
// Classification readout: captures the final layer outputs on a rising done,
// scans them serially for the signed maximum, and presents index + value over
// a valid/ready handshake.
module layer_argmax_reader
    import nn_pkg::*;
#(
    parameter  int DATA_BITS = 24,
    parameter  int N_CLASSES = N_CLASSES_DEF,
    localparam int IDX_W     = idx_width(N_CLASSES)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [DATA_BITS:0]   data_in [0:N_CLASSES-1],
    input  logic                        done_in,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic        [IDX_W-1:0]     class_idx,
    output logic signed [DATA_BITS:0]   max_val,
    output logic                        busy,
    output logic                        overrun
);

    argmax_state_t              state_q, state_d;
    logic signed [DATA_BITS:0]  buf_q [0:N_CLASSES-1];
    logic signed [DATA_BITS:0]  max_q;
    logic        [IDX_W-1:0]    idx_q;
    logic        [IDX_W-1:0]    ptr_q;
    logic                       done_q;

    logic                       done_rise;
    logic                       capture;
    logic                       drop;
    logic                       accept;
    logic                       last;
    logic                       gt;
    logic signed [DATA_BITS:0]  cand;

    assign done_rise = done_in & ~done_q;
    assign accept    = (state_q == HOLD) & out_valid & out_ready;
    assign last      = (ptr_q == IDX_W'(N_CLASSES - 1));
    assign cand      = buf_q[ptr_q];
    assign gt        = (cand > max_q);
    assign drop      = done_rise & ~capture & (state_q != IDLE);
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accept coinciding with a new done rise re-captures
    // directly so back-to-back results lose no cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (done_rise) begin
                        capture = 1'b1;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture buffer, running max scan and result/handshake registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q    <= 1'b0;
            buf_q     <= '{default: '0};
            max_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            out_valid <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            overrun   <= 1'b0;
        end else begin
            done_q <= done_in;

            if (capture) begin
                buf_q   <= data_in;
                max_q   <= data_in[0];
                idx_q   <= '0;
                ptr_q   <= IDX_W'(1);
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                out_valid <= 1'b0;
            end

            if (state_q == SCAN) begin
                // Strictly greater replaces, so ties keep the lower index.
                if (gt) begin
                    max_q <= cand;
                    idx_q <= ptr_q;
                end
                if (last) begin
                    out_valid <= 1'b1;
                    class_idx <= gt ? ptr_q : idx_q;
                    max_val   <= gt ? cand : max_q;
                end else begin
                    ptr_q <= ptr_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_argmax_reader.sv
// Self-checking bench for layer_argmax_reader: a result-level model (argmax
// computed at capture, released after the scan latency) is compared against
// the DUT every cycle, plus literal expectations for the directed cases.
module tb_layer_argmax_reader;

    localparam int DB = 24;
    localparam int NC = 10;
    localparam int IW = 4;

    logic                 clk;
    logic                 rstn;
    logic signed [DB:0]   din [0:NC-1];
    logic                 done_in;
    logic                 out_ready;
    logic                 out_valid;
    logic        [IW-1:0] class_idx;
    logic signed [DB:0]   max_val;
    logic                 busy;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    layer_argmax_reader #(.DATA_BITS(DB), .N_CLASSES(NC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_in   (din),
        .done_in   (done_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .class_idx (class_idx),
        .max_val   (max_val),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt;        // scan edges still to go before the result appears
    int m_pidx, m_pmax;
    bit m_valid, m_ovr, m_done_q;
    int m_idx, m_max;

    task automatic m_capture();
        int bi, bv;
        bi = 0;
        bv = int'(din[0]);
        for (int i = 1; i < NC; i++) begin
            if (int'(din[i]) > bv) begin
                bv = int'(din[i]);
                bi = i;
            end
        end
        m_pidx = bi;
        m_pmax = bv;
        m_cnt  = NC - 1;
        m_ovr  = 1'b0;
    endtask

    always @(posedge clk or negedge rstn) begin
        bit rise;
        if (!rstn) begin
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_done_q = 0;
            m_idx = 0; m_max = 0; m_pidx = 0; m_pmax = 0;
        end else begin
            rise = done_in && !m_done_q;
            m_done_q = done_in;
            if (m_cnt > 0) begin
                if (rise) m_ovr = 1'b1;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_idx = m_pidx;
                    m_max = m_pmax;
                end
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    if (rise) m_capture();
                end else if (rise) begin
                    m_ovr = 1'b1;
                end
            end else if (rise) begin
                m_capture();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("class_idx", int'(class_idx), m_idx);
        chk("max_val",   int'(max_val),   m_max);
        chk("busy",      int'(busy),      int'(m_cnt > 0 || m_valid));
        chk("overrun",   int'(overrun),   int'(m_ovr));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v[NC]);
        for (int i = 0; i < NC; i++) din[i] = (DB+1)'(v[i]);
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    // Returns edges until out_valid, or -1 if the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    int t1[NC] = '{3, -5, 7, 2, 7, 0, -1, 1, 6, 4};
    int t2[NC] = '{-9, -3, -8, -10, -11, -12, -13, -14, -15, -20};
    int t5[NC] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};

    initial begin
        int n;
        int vcount;
        rstn = 1'b0;
        done_in = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NC; i++) din[i] = '0;
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_busy",  int'(busy), 0);
        rstn = 1'b1;
        tick();

        // 1: basic argmax, tie at index 4 ignored, latency 9
        load(t1);
        out_ready = 1'b1;
        pulse_done();
        wait_valid(n);
        chk("t1_latency", n, 9);
        chk("t1_idx", int'(class_idx), 2);
        chk("t1_max", int'(max_val), 7);
        chk("t1_model_idx", m_idx, 2);
        tick();
        chk("t1_accepted", int'(out_valid), 0);
        repeat (2) tick();

        // 2: all negative values
        load(t2);
        pulse_done();
        wait_valid(n);
        chk("t2_idx", int'(class_idx), 1);
        chk("t2_max", int'(max_val), -3);
        repeat (3) tick();

        // 3: done held high -> one result only
        load(t1);
        done_in = 1'b1;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        done_in = 1'b0;
        repeat (3) tick();
        chk("t3_results", vcount, 1);
        chk("t3_overrun", int'(overrun), 0);

        // 4: stall in HOLD, dropped done rise sets overrun
        out_ready = 1'b0;
        load(t2);
        pulse_done();
        wait_valid(n);
        chk("t4_latency", n, 9);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                load(t1);
                pulse_done();
            end else begin
                tick();
            end
        end
        chk("t4_hold_valid", int'(out_valid), 1);
        chk("t4_hold_idx", int'(class_idx), 1);
        chk("t4_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        tick();
        chk("t4_accept_valid", int'(out_valid), 0);
        chk("t4_idle_busy", int'(busy), 0);
        repeat (2) tick();

        // 5: accept edge coincides with a new done rise
        out_ready = 1'b0;
        load(t1);
        pulse_done();
        wait_valid(n);
        load(t5);
        out_ready = 1'b1;
        pulse_done();
        chk("t5_no_gap_busy", int'(busy), 1);
        chk("t5_accept", int'(out_valid), 0);
        wait_valid(n);
        chk("t5_latency", n, 9);
        chk("t5_idx", int'(class_idx), 9);
        chk("t5_max", int'(max_val), 100);
        chk("t5_overrun", int'(overrun), 0);
        tick();

        // 6: reset mid-scan (ptr=4)
        load(t1);
        pulse_done();
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_idx", int'(class_idx), 0);
        chk("t6_max", int'(max_val), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_overrun", int'(overrun), 0);
        tick();
        rstn = 1'b1;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("t6_no_result", vcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
